dnn_sample_sequencer: RTL and testbench

- Training/inference sample scheduler placed in front of the DNN top.
- Accepts sample descriptors (index, label, etapos) from the host over a valid/ready handshake.
- Generates the input-memory read stream so act0/ans0 chunks arrive aligned to the DNN block cycle, and drives etapos0.
- Tracks each label through the pipeline latency, scores actL_alln against it, and reports accuracy when a run of num_samples completes.

---
 rtl/dnn_sample_sequencer.sv | 148 ++++++++++++++
 tb/tb_dnn_sample_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_sample_sequencer.sv
// Sample scheduler in front of the DNN: accepts host descriptors at block-cycle
// boundaries, streams input-memory reads, tracks labels and scores predictions.
module dnn_sample_sequencer #(
    parameter int CPC = 18,
    parameter int NOUT = 16,
    parameter int RES_LAT = 3,
    parameter int ETAPOS_W = 4,
    parameter logic [ETAPOS_W-1:0] ETAPOS_NOP = '0,
    parameter int IDX_W = 12,
    parameter int ADDR_W = 16,
    parameter int CNT_W = 16,
    localparam int CI_W = $clog2(CPC),
    localparam int LBL_W = $clog2(NOUT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CI_W-1:0]     cycle_index,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    input  logic                smp_valid,
    output logic                smp_ready,
    input  logic [IDX_W-1:0]    smp_index,
    input  logic [LBL_W-1:0]    smp_label,
    input  logic [ETAPOS_W-1:0] smp_etapos,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [ETAPOS_W-1:0] etapos0,
    input  logic [NOUT-1:0]     actL_alln,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sample_count,
    output logic [CNT_W-1:0]    correct_count
);
    localparam int DR_W = $clog2(RES_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t            state;
    logic [CNT_W-1:0]  num_q;
    logic              pipe_valid [RES_LAT];
    logic [LBL_W-1:0]  pipe_label [RES_LAT];
    logic              out_valid;
    logic [LBL_W-1:0]  out_label;
    logic              slot_active;
    logic [ADDR_W-1:0] base;
    logic [DR_W-1:0]   drain_cnt;

    logic              boundary;
    logic              score_pt;
    logic              hs;
    logic              chunk_rd;
    logic              hit;
    logic [ADDR_W-1:0] hs_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Handshake is only possible on the boundary clock; chunk 0 goes out on
    // that same clock, the remaining chunks follow at cycle_index 0..CPC-4.
    assign boundary  = (cycle_index == CI_W'(CPC - 1));
    assign score_pt  = (cycle_index == '0);
    assign smp_ready = (state == RUN) && boundary && (sample_count < num_q);
    assign hs        = smp_ready && smp_valid;
    assign hs_base   = ADDR_W'(smp_index) * ADDR_W'(CPC - 2);
    assign chunk_rd  = slot_active && (cycle_index <= CI_W'(CPC - 4));
    assign mem_rd_en = hs || chunk_rd;
    assign mem_addr  = hs ? hs_base :
                       chunk_rd ? base + ADDR_W'(cycle_index) + ADDR_W'(1) : '0;
    assign hit       = out_valid && (actL_alln == (NOUT'(1) << out_label));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            etapos0       <= ETAPOS_NOP;
            sample_count  <= '0;
            correct_count <= '0;
            num_q         <= '0;
            out_valid     <= 1'b0;
            out_label     <= '0;
            slot_active   <= 1'b0;
            base          <= '0;
            drain_cnt     <= '0;
            for (int i = 0; i < RES_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_label[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sample_count  <= '0;
                        correct_count <= '0;
                        num_q         <= num_samples;
                        out_valid     <= 1'b0;
                        drain_cnt     <= '0;
                        for (int i = 0; i < RES_LAT; i++) pipe_valid[i] <= 1'b0;
                        if (num_samples == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    if (score_pt && out_valid) begin
                        out_valid <= 1'b0;
                        if (hit) correct_count <= sat_inc(correct_count);
                    end
                    if (boundary) begin
                        for (int i = RES_LAT - 1; i > 0; i--) begin
                            pipe_valid[i] <= pipe_valid[i-1];
                            pipe_label[i] <= pipe_label[i-1];
                        end
                        pipe_valid[0] <= hs;
                        pipe_label[0] <= smp_label;
                        out_valid     <= pipe_valid[RES_LAT-1];
                        out_label     <= pipe_label[RES_LAT-1];
                        slot_active   <= hs;
                        etapos0       <= hs ? smp_etapos : ETAPOS_NOP;
                        if (hs) begin
                            base         <= hs_base;
                            sample_count <= sat_inc(sample_count);
                        end
                        if (state == RUN && (sample_count + CNT_W'(hs) == num_q))
                            state <= DRAIN;
                        if (state == DRAIN)
                            drain_cnt <= drain_cnt + DR_W'(1);
                    end
                    // Last sample leaves the pipe on the RES_LAT-th drain boundary
                    // and is scored on the following cycle_index 0.
                    if (state == DRAIN && drain_cnt == DR_W'(RES_LAT) && score_pt) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dnn_sample_sequencer.sv
// Self-checking bench: a slot calendar model predicts reads, etapos, scoring and done.
module tb_dnn_sample_sequencer;
    localparam int CPC = 18;
    localparam int NOUT = 16;
    localparam int RES_LAT = 3;
    localparam int ETAPOS_W = 4;
    localparam int IDX_W = 12;
    localparam int ADDR_W = 16;
    localparam int CNT_W = 16;
    localparam int CI_W = $clog2(CPC);
    localparam int LBL_W = $clog2(NOUT);
    // clocks from a handshake to the clock on which its prediction is scored
    localparam int SCORE_LAT = RES_LAT * CPC + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [CI_W-1:0]     cycle_index;
    logic                start;
    logic [CNT_W-1:0]    num_samples;
    logic                smp_valid;
    logic                smp_ready;
    logic [IDX_W-1:0]    smp_index;
    logic [LBL_W-1:0]    smp_label;
    logic [ETAPOS_W-1:0] smp_etapos;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [ETAPOS_W-1:0] etapos0;
    logic [NOUT-1:0]     actL_alln;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    sample_count;
    logic [CNT_W-1:0]    correct_count;

    int cyc;
    int passed;
    int total;

    dnn_sample_sequencer dut (
        .clk(clk), .reset(reset), .cycle_index(cycle_index), .start(start),
        .num_samples(num_samples), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_index(smp_index), .smp_label(smp_label), .smp_etapos(smp_etapos),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .etapos0(etapos0),
        .actL_alln(actL_alln), .busy(busy), .done(done),
        .sample_count(sample_count), .correct_count(correct_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        cycle_index = CI_W'(cyc % CPC);
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(smp_ready), 0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_etapos"}, 32'(etapos0), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_smp_cnt"}, 32'(sample_count), 0);
        chk({tag, "_cor_cnt"}, 32'(correct_count), 0);
    endtask

    // One run: skip_slot withholds valid on that slot, wrong_idx gets a bad
    // prediction, drain_off pulses start that many clocks after the last
    // handshake, abort pulls reset at cycle_index 7 after the first handshake.
    task automatic run(input int n, input int skip_slot, input int wrong_idx,
                       input int drain_off, input bit abort, input bit fixed_first);
        logic [ADDR_W-1:0]   exp_addr [int];
        logic [ETAPOS_W-1:0] exp_eta [int];
        logic [NOUT-1:0]     score_val [int];
        int s, issued, slot, correct_exp, t_last, exp_done, limit, idx, lbl, eta;
        bit finished;
        s = cyc;
        issued = 0;
        slot = 0;
        correct_exp = 0;
        t_last = -1;
        exp_done = (n == 0) ? s + 1 : 32'h7fff_ffff;
        limit = cyc + (n + RES_LAT + 4) * CPC + 40;
        finished = 1'b0;
        while (cyc <= limit && !finished) begin
            bit bnd;
            bit hs;
            logic [NOUT-1:0] pred;
            bit drain_start;
            drain_start = (drain_off >= 0) && (t_last >= 0) && (cyc == t_last + drain_off);
            start = (cyc == s) || drain_start;
            num_samples = drain_start ? CNT_W'($urandom_range(1, 9)) : CNT_W'(n);
            bnd = (cyc % CPC == CPC - 1) && (cyc > s) && (issued < n);
            hs = 1'b0;
            idx = $urandom_range(0, (1 << IDX_W) - 1);
            lbl = $urandom_range(0, NOUT - 1);
            eta = $urandom_range(1, (1 << ETAPOS_W) - 1);
            if (fixed_first && issued == 0) begin
                idx = 2;
                lbl = 5;
                eta = 3;
            end
            smp_index = IDX_W'(idx);
            smp_label = LBL_W'(lbl);
            smp_etapos = ETAPOS_W'(eta);
            if (bnd) begin
                hs = (slot != skip_slot);
                smp_valid = hs;
                slot++;
            end else begin
                smp_valid = ($urandom_range(0, 3) == 0);
            end
            if (hs) begin
                for (int c = 0; c < CPC - 2; c++) exp_addr[cyc + c] = ADDR_W'(idx * (CPC - 2) + c);
                for (int d = 1; d <= CPC; d++) exp_eta[cyc + d] = ETAPOS_W'(eta);
                pred = '0;
                if (issued == wrong_idx) pred[(lbl + 1) % NOUT] = 1'b1;
                else begin
                    pred[lbl] = 1'b1;
                    correct_exp++;
                end
                score_val[cyc + SCORE_LAT] = pred;
                issued++;
                if (issued == n) begin
                    t_last = cyc;
                    exp_done = cyc + SCORE_LAT + 1;
                end
            end
            actL_alln = score_val.exists(cyc) ? score_val[cyc] : '0;
            settle();
            if (abort && issued >= 1 && (cyc % CPC == 7)) begin
                reset = 1'b0;
                #1;
                check_all_zero("abort");
                for (int k = 0; k < 3; k++) begin
                    advance();
                    start = 1'b0;
                    smp_valid = 1'b0;
                    settle();
                    chk("abort_hold_done", 32'(done), 0);
                    chk("abort_hold_busy", 32'(busy), 0);
                end
                reset = 1'b1;
                advance();
                return;
            end
            chk("ready", 32'(smp_ready), 32'(bnd));
            chk("rd_en", 32'(mem_rd_en), 32'(exp_addr.exists(cyc)));
            if (exp_addr.exists(cyc)) chk("addr", 32'(mem_addr), 32'(exp_addr[cyc]));
            chk("etapos0", 32'(etapos0), exp_eta.exists(cyc) ? 32'(exp_eta[cyc]) : 0);
            chk("done", 32'(done), 32'(cyc == exp_done));
            chk("busy", 32'(busy), 32'((n > 0) && (cyc > s) && (cyc < exp_done)));
            if (cyc == exp_done) begin
                chk("sample_count", 32'(sample_count), 32'(n));
                chk("correct_count", 32'(correct_count), 32'(correct_exp));
            end
            if (cyc == exp_done + 1) begin
                chk("sample_count_hold", 32'(sample_count), 32'(n));
                chk("correct_count_hold", 32'(correct_count), 32'(correct_exp));
                finished = 1'b1;
            end
            advance();
        end
        chk("run_completed", 32'(finished), 1);
        start = 1'b0;
        smp_valid = 1'b0;
        actL_alln = '0;
    endtask

    initial begin
        passed = 0;
        total = 0;
        cyc = 0;
        cycle_index = '0;
        reset = 1'b0;
        start = 1'b0;
        num_samples = '0;
        smp_valid = 1'b0;
        smp_index = '0;
        smp_label = '0;
        smp_etapos = '0;
        actL_alln = '0;
        settle();
        check_all_zero("reset");
        repeat (3) advance();
        reset = 1'b1;

        for (int i = 0; i < 100; i++) begin
            smp_valid = ($urandom_range(0, 1) == 1);
            settle();
            chk("idle_ready", 32'(smp_ready), 0);
            chk("idle_rd_en", 32'(mem_rd_en), 0);
            chk("idle_etapos", 32'(etapos0), 0);
            advance();
        end
        smp_valid = 1'b0;

        run(1, -1, -1, -1, 1'b0, 1'b1);
        repeat (5) advance();
        run(4, 2, 2, -1, 1'b0, 1'b0);
        run(0, -1, -1, -1, 1'b0, 1'b0);
        repeat (7) advance();
        run(4, 2, 2, -1, 1'b1, 1'b0);
        run(4, 2, 2, -1, 1'b0, 1'b0);
        run(3, -1, -1, 20, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 20)) advance();
            run($urandom_range(1, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                -1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
